accelerator_transformer_attention_score: RTL and testbench

Streaming scaled dot-product score stage for the standard transformer accelerator: it latches one query vector, then consumes key vectors element by element. For each key row it emits one fixed-point score, sat((q·k) >>> SHIFT). These scores feed the attention softmax/weighting stage downstream. Sizes and data widths come from the standard-transformer system constants.

---
 rtl/accelerator_transformer_attention_score_if.sv | 33 +++
 rtl/accelerator_transformer_attention_score.sv | 155 +++++++++++++++
 tb/tb_accelerator_transformer_attention_score.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accelerator_transformer_attention_score_if.sv
// Handshake and data bundle for the attention score stage.
// The master drives query/key streams and sizes; the slave returns scores.
interface accelerator_transformer_attention_score_if #(
    parameter int DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic [DATA_SIZE-1:0] SIZE_W_IN;
    logic [DATA_SIZE-1:0] SIZE_L_IN;
    logic [DATA_SIZE-1:0] Q_IN;
    logic                 Q_IN_ENABLE;
    logic                 Q_IN_READY;
    logic [DATA_SIZE-1:0] K_IN;
    logic                 K_IN_ENABLE;
    logic                 K_IN_READY;
    logic [DATA_SIZE-1:0] SCORE_OUT;
    logic                 SCORE_OUT_ENABLE;
    logic [DATA_SIZE-1:0] SCORE_INDEX_OUT;

    modport master (
        output START, SIZE_W_IN, SIZE_L_IN,
        output Q_IN, Q_IN_ENABLE, K_IN, K_IN_ENABLE,
        input  READY, Q_IN_READY, K_IN_READY,
        input  SCORE_OUT, SCORE_OUT_ENABLE, SCORE_INDEX_OUT
    );

    modport slave (
        input  START, SIZE_W_IN, SIZE_L_IN,
        input  Q_IN, Q_IN_ENABLE, K_IN, K_IN_ENABLE,
        output READY, Q_IN_READY, K_IN_READY,
        output SCORE_OUT, SCORE_OUT_ENABLE, SCORE_INDEX_OUT
    );
endinterface

// File: rtl/accelerator_transformer_attention_score.sv
// Streaming scaled dot-product score stage: latch a query vector, then
// emit sat((q.k) >>> SHIFT) once per streamed key row.
module accelerator_transformer_attention_score #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int W            = 64,
    parameter int L            = 64,
    parameter int SHIFT        = 3
) (
    input logic CLK,
    input logic RST,
    accelerator_transformer_attention_score_if.slave bus
);
    localparam int JW = (W > 1) ? $clog2(W) : 1;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam int AW = 2 * DATA_SIZE;

    localparam logic [DATA_SIZE-1:0] SAT_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] SAT_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD_Q,
        SCORE,
        EMIT
    } state_t;

    state_t                       r_state;
    logic signed [DATA_SIZE-1:0]  r_q [W];
    logic        [JW-1:0]         r_j;
    logic        [LW-1:0]         r_l;
    logic        [JW-1:0]         r_w_last;
    logic        [LW-1:0]         r_l_last;
    logic signed [AW-1:0]         r_acc;
    logic                         r_ready;
    logic                         r_q_rdy;
    logic                         r_k_rdy;
    logic                         r_score_en;
    logic        [DATA_SIZE-1:0]  r_score;
    logic        [DATA_SIZE-1:0]  r_index;

    logic        [DATA_SIZE-1:0]  w_sw;
    logic        [DATA_SIZE-1:0]  w_sl;
    logic signed [AW-1:0]         w_q_ext;
    logic signed [AW-1:0]         w_k_ext;
    logic signed [AW-1:0]         w_acc_next;
    logic signed [AW-1:0]         w_sh;
    logic        [DATA_SIZE:0]    w_top;
    logic        [DATA_SIZE-1:0]  w_sat;
    logic                         w_unused_ctrl;

    assign w_unused_ctrl = |CONTROL_SIZE;

    assign w_sw = (bus.SIZE_W_IN > DATA_SIZE'(W)) ? DATA_SIZE'(W)
                                                  : bus.SIZE_W_IN;
    assign w_sl = (bus.SIZE_L_IN > DATA_SIZE'(L)) ? DATA_SIZE'(L)
                                                  : bus.SIZE_L_IN;

    // Full-width signed product, accumulated with wraparound.
    assign w_q_ext    = AW'(r_q[r_j]);
    assign w_k_ext    = AW'($signed(bus.K_IN));
    assign w_acc_next = r_acc + (w_q_ext * w_k_ext);

    // In range iff the bits above the result sign all match it.
    assign w_sh  = w_acc_next >>> SHIFT;
    assign w_top = w_sh[AW-1:DATA_SIZE-1];
    assign w_sat = ((&w_top) || (~|w_top)) ? w_sh[DATA_SIZE-1:0]
                 : (w_sh[AW-1] ? SAT_MIN : SAT_MAX);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            for (int i = 0; i < W; i++) r_q[i] <= '0;
            r_j        <= '0;
            r_l        <= '0;
            r_w_last   <= '0;
            r_l_last   <= '0;
            r_acc      <= '0;
            r_ready    <= 1'b0;
            r_q_rdy    <= 1'b0;
            r_k_rdy    <= 1'b0;
            r_score_en <= 1'b0;
            r_score    <= '0;
            r_index    <= '0;
        end else begin
            r_ready    <= 1'b0;
            r_score_en <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.START) begin
                        r_w_last <= JW'(w_sw - DATA_SIZE'(1));
                        r_l_last <= LW'(w_sl - DATA_SIZE'(1));
                        if (w_sw == '0 || w_sl == '0) begin
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= LOAD_Q;
                            r_q_rdy <= 1'b1;
                            r_j     <= '0;
                            r_l     <= '0;
                        end
                    end
                end
                LOAD_Q: begin
                    if (bus.Q_IN_ENABLE) begin
                        r_q[r_j] <= $signed(bus.Q_IN);
                        if (r_j == r_w_last) begin
                            r_j     <= '0;
                            r_acc   <= '0;
                            r_state <= SCORE;
                            r_q_rdy <= 1'b0;
                            r_k_rdy <= 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                end
                SCORE: begin
                    if (bus.K_IN_ENABLE) begin
                        r_acc <= w_acc_next;
                        if (r_j == r_w_last) begin
                            // Outputs for the EMIT cycle are registered here.
                            r_state    <= EMIT;
                            r_k_rdy    <= 1'b0;
                            r_score_en <= 1'b1;
                            r_score    <= w_sat;
                            r_index    <= DATA_SIZE'(r_l);
                            r_ready    <= (r_l == r_l_last);
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (r_l == r_l_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_l     <= r_l + 1'b1;
                        r_j     <= '0;
                        r_acc   <= '0;
                        r_state <= SCORE;
                        r_k_rdy <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.READY            = r_ready;
    assign bus.Q_IN_READY       = r_q_rdy;
    assign bus.K_IN_READY       = r_k_rdy;
    assign bus.SCORE_OUT        = r_score;
    assign bus.SCORE_OUT_ENABLE = r_score_en;
    assign bus.SCORE_INDEX_OUT  = r_index;
endmodule

// File: tb/tb_accelerator_transformer_attention_score.sv
// Directed bench for the attention score stage: basic, saturation,
// gapped/illegal enables, size boundaries, async reset and full size.
module tb_accelerator_transformer_attention_score;
    localparam int D = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    accelerator_transformer_attention_score_if #(.DATA_SIZE(D)) bus ();

    accelerator_transformer_attention_score #(
        .DATA_SIZE(D), .CONTROL_SIZE(4), .W(64), .L(64), .SHIFT(3)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] sc_q [$];
    logic [63:0] ix_q [$];
    int   ready_cnt = 0;
    int   ready_cyc = 0;
    logic ready_en  = 1'b0;
    int   start_cyc = 0;

    always @(negedge clk) begin
        if (bus.SCORE_OUT_ENABLE) begin
            sc_q.push_back(bus.SCORE_OUT);
            ix_q.push_back(bus.SCORE_INDEX_OUT);
        end
        if (bus.READY) begin
            ready_cnt = ready_cnt + 1;
            ready_cyc = cyc;
            ready_en  = bus.SCORE_OUT_ENABLE;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sc_at(input int i);
        return (i < sc_q.size()) ? sc_q[i] : 'x;
    endfunction

    function automatic logic [63:0] ix_at(input int i);
        return (i < ix_q.size()) ? ix_q[i] : 'x;
    endfunction

    task automatic clr();
        sc_q.delete();
        ix_q.delete();
        ready_cnt = 0;
        ready_en  = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.START       = 1'b0;
        bus.SIZE_W_IN   = '0;
        bus.SIZE_L_IN   = '0;
        bus.Q_IN        = '0;
        bus.Q_IN_ENABLE = 1'b0;
        bus.K_IN        = '0;
        bus.K_IN_ENABLE = 1'b0;
    endtask

    task automatic start_run(input logic [63:0] w, input logic [63:0] l);
        bus.START     = 1'b1;
        bus.SIZE_W_IN = w;
        bus.SIZE_L_IN = l;
        start_cyc     = cyc;
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic send_q(input logic [63:0] v, input int gap,
                          input bit noisy);
        int n;
        bus.Q_IN_ENABLE = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.K_IN_ENABLE = noisy;
            bus.K_IN        = 64'h0BAD_0BAD_0BAD_0BAD;
            @(negedge clk);
        end
        bus.K_IN_ENABLE = 1'b0;
        n = 0;
        while (!bus.Q_IN_READY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.Q_IN_READY) check("q_ready_wait", bus.Q_IN_READY, 1);
        bus.Q_IN        = v;
        bus.Q_IN_ENABLE = 1'b1;
        @(negedge clk);
        bus.Q_IN_ENABLE = 1'b0;
    endtask

    task automatic send_k(input logic [63:0] v, input int gap,
                          input bit noisy);
        int n;
        bus.K_IN_ENABLE = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.Q_IN_ENABLE = noisy;
            bus.Q_IN        = 64'h7777_7777_7777_7777;
            @(negedge clk);
        end
        bus.Q_IN_ENABLE = 1'b0;
        n = 0;
        while (!bus.K_IN_READY && n < 50) begin
            bus.K_IN_ENABLE = noisy;
            bus.K_IN        = 64'h5555_5555_5555_5555;
            @(negedge clk);
            n++;
        end
        if (!bus.K_IN_READY) check("k_ready_wait", bus.K_IN_READY, 1);
        bus.K_IN        = v;
        bus.K_IN_ENABLE = 1'b1;
        @(negedge clk);
        bus.K_IN_ENABLE = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int limit);
        int n;
        n = 0;
        while (!bus.READY && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!bus.READY) check({tag, "_ready_timeout"}, bus.READY, 1);
        @(negedge clk);
        check({tag, "_ready_one_cycle"}, bus.READY, 0);
    endtask

    task automatic basic_body(input bit gapped);
        logic [63:0] qv [4];
        logic [63:0] k1 [4];
        int gmax;
        qv = '{64'd1, 64'd2, 64'd3, 64'd4};
        k1 = '{-64'sd8, 64'd0, 64'd0, 64'd0};
        gmax = gapped ? 3 : 0;
        for (int j = 0; j < 4; j++)
            send_q(qv[j], $urandom_range(0, gmax), gapped);
        for (int j = 0; j < 4; j++)
            send_k(64'd8, $urandom_range(0, gmax), gapped);
        for (int j = 0; j < 4; j++)
            send_k(k1[j], $urandom_range(0, gmax), gapped);
    endtask

    task automatic expect_two(input string t, input logic [63:0] s0,
                              input logic [63:0] s1);
        check({t, "_count"}, sc_q.size(), 2);
        check({t, "_s0"}, sc_at(0), s0);
        check({t, "_i0"}, ix_at(0), 0);
        check({t, "_s1"}, sc_at(1), s1);
        check({t, "_i1"}, ix_at(1), 1);
        check({t, "_ready_cnt"}, ready_cnt, 1);
        check({t, "_ready_with_en"}, ready_en, 1);
    endtask

    initial begin
        idle_inputs();
        repeat (3) @(negedge clk);

        check("rst_flags",
              {bus.READY, bus.Q_IN_READY, bus.K_IN_READY, bus.SCORE_OUT_ENABLE},
              0);
        check("rst_score", bus.SCORE_OUT, 0);
        check("rst_index", bus.SCORE_INDEX_OUT, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic W=4, L=2: 80>>>3=10, -8>>>3=-1
        clr();
        start_run(4, 2);
        check("basic_qrdy_after_start", bus.Q_IN_READY, 1);
        basic_body(1'b0);
        wait_ready("basic", 20);
        expect_two("basic", 64'd10, -64'sd1);
        check("basic_cycles", ready_cyc - start_cyc + 1, 15);
        check("basic_hold_score", bus.SCORE_OUT, -64'sd1);
        check("basic_hold_index", bus.SCORE_INDEX_OUT, 1);

        // Saturation W=1, L=2
        clr();
        start_run(1, 2);
        send_q(64'h4000_0000_0000_0000, 0, 0);
        send_k(64'h4000_0000_0000_0000, 0, 0);
        send_k(64'hC000_0000_0000_0000, 0, 0);
        wait_ready("sat", 20);
        expect_two("sat", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);

        // Gapped stimulus with enables asserted while not ready
        clr();
        start_run(4, 2);
        basic_body(1'b1);
        wait_ready("gap", 40);
        expect_two("gap", 64'd10, -64'sd1);

        // SIZE_L_IN = 0
        clr();
        start_run(4, 0);
        check("l0_ready_next", bus.READY, 1);
        check("l0_no_qrdy", bus.Q_IN_READY, 0);
        repeat (4) @(negedge clk);
        check("l0_no_scores", sc_q.size(), 0);
        check("l0_ready_cnt", ready_cnt, 1);

        // SIZE_W_IN = 0
        clr();
        start_run(0, 3);
        check("w0_ready_next", bus.READY, 1);
        repeat (4) @(negedge clk);
        check("w0_no_scores", sc_q.size(), 0);

        // SIZE_W_IN = 100 clamps to 64: 64*2*3=384, >>>3 = 48
        clr();
        start_run(100, 1);
        for (int j = 0; j < 64; j++) send_q(64'd2, 0, 0);
        for (int j = 0; j < 64; j++) send_k(64'd3, 0, 0);
        wait_ready("w100", 20);
        check("w100_count", sc_q.size(), 1);
        check("w100_score", sc_at(0), 48);
        check("w100_cycles", ready_cyc - start_cyc + 1, 130);

        // START during SCORE is ignored
        clr();
        start_run(4, 2);
        for (int j = 0; j < 4; j++) send_q(64'(j + 1), 0, 0);
        bus.START     = 1'b1;
        bus.SIZE_W_IN = 64'd1;
        bus.SIZE_L_IN = 64'd1;
        @(negedge clk);
        bus.START = 1'b0;
        for (int j = 0; j < 4; j++) send_k(64'd8, 0, 0);
        send_k(-64'sd8, 0, 0);
        for (int j = 0; j < 3; j++) send_k(64'd0, 0, 0);
        wait_ready("stscore", 20);
        expect_two("stscore", 64'd10, -64'sd1);

        // Async reset in row 1 of 2
        clr();
        start_run(4, 2);
        for (int j = 0; j < 4; j++) send_q(64'(j + 1), 0, 0);
        for (int j = 0; j < 4; j++) send_k(64'd8, 0, 0);
        send_k(-64'sd8, 0, 0);
        send_k(64'd0, 0, 0);
        check("mid_pre_score", bus.SCORE_OUT, 10);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_flags",
              {bus.READY, bus.Q_IN_READY, bus.K_IN_READY, bus.SCORE_OUT_ENABLE},
              0);
        check("mid_rst_score", bus.SCORE_OUT, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        clr();
        start_run(4, 2);
        basic_body(1'b0);
        wait_ready("post_rst", 20);
        expect_two("post_rst", 64'd10, -64'sd1);

        // Max size: every score is 64>>>3 = 8
        clr();
        start_run(64, 64);
        for (int j = 0; j < 64; j++) send_q(64'd1, 0, 0);
        for (int l = 0; l < 64; l++)
            for (int j = 0; j < 64; j++) send_k(64'd1, 0, 0);
        wait_ready("max", 20);
        check("max_count", sc_q.size(), 64);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("max_s%0d", i), sc_at(i), 8);
            check($sformatf("max_i%0d", i), ix_at(i), 64'(i));
        end
        check("max_cycles", ready_cyc - start_cyc + 1, 1 + 64 + 64 * 65);
        check("max_ready_cnt", ready_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
